// File: rtl/prog_counter.sv
// Programmable wrap counter with load, clear and one-shot/free-run FSM.
// Define PROG_COUNTER_MID_PULSE_EN to add the o_mid half-period strobe.
module prog_counter #(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_count_enable,
  input  logic                     i_start,
  input  logic                     i_clear,
  input  logic                     i_load,
  input  logic [COUNTER_WIDTH-1:0] i_load_value,
  input  logic [COUNTER_WIDTH-1:0] i_terminal,
  input  logic                     i_oneshot,
  output logic [COUNTER_WIDTH-1:0] o_count,
  output logic                     o_overflow,
`ifdef PROG_COUNTER_MID_PULSE_EN
  output logic                     o_mid,
`endif
  output logic                     o_busy
);

  localparam int W = COUNTER_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  logic           wrap;
  logic           inc_en;
  logic [W-1:0]   count_inc;

  assign wrap      = (o_count == i_terminal) || (&o_count);
  assign inc_en    = (state == RUN) && i_count_enable;
  assign count_inc = o_count + 1'b1;

`ifdef PROG_COUNTER_MID_PULSE_EN
  logic [W:0]   term_p1;
  logic [W-1:0] mid_val;
  logic         mid_hit;

  // Half period computed one bit wider so i_terminal=all-ones does not wrap.
  assign term_p1 = {1'b0, i_terminal} + 1'b1;
  assign mid_val = term_p1[W:1];
  assign mid_hit = inc_en && !i_load && !wrap
                && (i_terminal != '0)
                && (count_inc == mid_val);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      o_mid <= 1'b0;
    end else if (i_clear) begin
      o_mid <= 1'b0;
    end else begin
      o_mid <= mid_hit;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_busy     <= 1'b0;
    end else if (i_clear) begin
      state      <= IDLE;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_overflow <= 1'b0;
      if (i_load) begin
        o_count <= i_load_value;
      end else if (inc_en) begin
        if (wrap) begin
          o_count    <= '0;
          o_overflow <= 1'b1;
        end else begin
          o_count <= count_inc;
        end
      end
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state  <= RUN;
            o_busy <= 1'b1;
          end
        end
        RUN: begin
          // A load wins over the wrap, so it also blocks the one-shot stop.
          if (!i_load && inc_en && wrap && i_oneshot) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: directed vectors push expected
// outputs, a monitor pops and compares one entry per clock.
module tb_prog_counter;

  logic       CLK;
  logic       RST;
  logic       i_count_enable;
  logic       i_start;
  logic       i_clear;
  logic       i_load;
  logic [7:0] i_load_value;
  logic [7:0] i_terminal;
  logic       i_oneshot;
  logic [7:0] o_count;
  logic       o_overflow;
  logic       o_busy;
`ifdef PROG_COUNTER_MID_PULSE_EN
  logic       o_mid;
`endif

  prog_counter #(.COUNTER_WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .i_count_enable(i_count_enable),
    .i_start(i_start),
    .i_clear(i_clear),
    .i_load(i_load),
    .i_load_value(i_load_value),
    .i_terminal(i_terminal),
    .i_oneshot(i_oneshot),
    .o_count(o_count),
    .o_overflow(o_overflow),
`ifdef PROG_COUNTER_MID_PULSE_EN
    .o_mid(o_mid),
`endif
    .o_busy(o_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] c;
    logic       ov;
    logic       busy;
    logic       mid;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  // Monitor: one expected entry per clock, sampled 1 ns after the edge.
  initial begin
    exp_t e;
    logic mid_act;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        mid_act = e.mid;
`ifdef PROG_COUNTER_MID_PULSE_EN
        mid_act = o_mid;
`endif
        checks++;
        if (o_count !== e.c || o_overflow !== e.ov ||
            o_busy !== e.busy || mid_act !== e.mid) begin
          errors++;
          $display("FAIL vec%0d: got cnt=%h ov=%b busy=%b mid=%b, want cnt=%h ov=%b busy=%b mid=%b",
                   vec, o_count, o_overflow, o_busy, mid_act,
                   e.c, e.ov, e.busy, e.mid);
        end
        vec++;
      end
    end
  end

  task automatic tick(input logic [7:0] c, input logic ov,
                      input logic busy, input logic mid);
    exp_t e;
    e.c = c; e.ov = ov; e.busy = busy; e.mid = mid;
    q.push_back(e);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b0;
    i_count_enable = 1'b0;
    i_start = 1'b0;
    i_clear = 1'b0;
    i_load = 1'b0;
    i_load_value = 8'h00;
    i_terminal = 8'h00;
    i_oneshot = 1'b0;

    // Reset, then start: busy rises, count stays 0
    tick(8'h00, 0, 0, 0);
    tick(8'h00, 0, 0, 0);
    RST = 1'b1; i_start = 1'b1;
    tick(8'h00, 0, 1, 0);
    i_start = 1'b0;

    // Free-run, terminal 3 (mid at 2)
    i_terminal = 8'd3; i_count_enable = 1'b1;
    tick(8'd1, 0, 1, 0);
    tick(8'd2, 0, 1, 1);
    tick(8'd3, 0, 1, 0);
    tick(8'd0, 1, 1, 0);
    tick(8'd1, 0, 1, 0);
    tick(8'd2, 0, 1, 1);
    tick(8'd3, 0, 1, 0);
    tick(8'd0, 1, 1, 0);

    // Clear stops the FSM
    i_clear = 1'b1;
    tick(8'd0, 0, 0, 0);
    i_clear = 1'b0;

    // One-shot, terminal 4 (mid at 2)
    i_terminal = 8'd4; i_oneshot = 1'b1;
    i_count_enable = 1'b0; i_start = 1'b1;
    tick(8'd0, 0, 1, 0);
    i_start = 1'b0; i_count_enable = 1'b1;
    tick(8'd1, 0, 1, 0);
    tick(8'd2, 0, 1, 1);
    tick(8'd3, 0, 1, 0);
    tick(8'd4, 0, 1, 0);
    tick(8'd0, 1, 0, 0);
    tick(8'd0, 0, 0, 0);
    tick(8'd0, 0, 0, 0);

    // Load above terminal in RUN runs to all-ones then wraps
    i_terminal = 8'h10; i_oneshot = 1'b0;
    i_count_enable = 1'b0; i_start = 1'b1;
    tick(8'd0, 0, 1, 0);
    i_start = 1'b0;
    i_load = 1'b1; i_load_value = 8'hFE; i_count_enable = 1'b1;
    tick(8'hFE, 0, 1, 0);
    i_load = 1'b0;
    tick(8'hFF, 0, 1, 0);
    tick(8'h00, 1, 1, 0);

    // Clear overrides load and start
    i_clear = 1'b1; i_load = 1'b1; i_start = 1'b1; i_load_value = 8'h55;
    tick(8'd0, 0, 0, 0);
    i_clear = 1'b0;

    // Load + start together in IDLE, then one-shot from 2 to terminal 5
    i_load_value = 8'd2; i_terminal = 8'd5; i_oneshot = 1'b1;
    tick(8'd2, 0, 1, 0);
    i_load = 1'b0; i_start = 1'b0;
    tick(8'd3, 0, 1, 1);
    tick(8'd4, 0, 1, 0);
    tick(8'd5, 0, 1, 0);
    tick(8'd0, 1, 0, 0);

    // Terminal 0 with gated enable
    i_terminal = 8'd0; i_oneshot = 1'b0;
    i_count_enable = 1'b0; i_start = 1'b1;
    tick(8'd0, 0, 1, 0);
    i_start = 1'b0;
    i_count_enable = 1'b1; tick(8'd0, 1, 1, 0);
    i_count_enable = 1'b0; tick(8'd0, 0, 1, 0);
    i_count_enable = 1'b1; tick(8'd0, 1, 1, 0);
    tick(8'd0, 1, 1, 0);
    i_count_enable = 1'b0; tick(8'd0, 0, 1, 0);

    // Terminal changed mid-period takes effect at once
    i_terminal = 8'd10; i_count_enable = 1'b1;
    tick(8'd1, 0, 1, 0);
    tick(8'd2, 0, 1, 0);
    tick(8'd3, 0, 1, 0);
    i_terminal = 8'd3;
    tick(8'd0, 1, 1, 0);

    // Reset mid-period at count 5 (terminal 10, mid at 5)
    i_terminal = 8'd10;
    tick(8'd1, 0, 1, 0);
    tick(8'd2, 0, 1, 0);
    tick(8'd3, 0, 1, 0);
    tick(8'd4, 0, 1, 0);
    tick(8'd5, 0, 1, 1);
    RST = 1'b0;
    tick(8'd0, 0, 0, 0);
    RST = 1'b1; i_count_enable = 1'b0;

    // Terminal 15 free-run: mid as count becomes 8, two periods
    i_terminal = 8'd15; i_start = 1'b1;
    tick(8'd0, 0, 1, 0);
    i_start = 1'b0; i_count_enable = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick(8'(i % 16), (i % 16) == 0, 1'b1, (i % 16) == 8);
    end

    // Start in RUN is ignored, count keeps going
    i_start = 1'b1;
    tick(8'd1, 0, 1, 0);
    i_start = 1'b0;
    tick(8'd2, 0, 1, 0);

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge CLK);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
